data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_load_align.sv | 29 ++
 rtl/data_cache.sv | 166 ++++++++++++++++
 tb/tb_data_cache.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// States, load/store funct3 encodings and cache geometry.
package dcache_pkg;

  localparam int LINES       = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int IDX_W       = 3;
  localparam int TAG_W       = 25;
  localparam int LINE_W      = BLOCK_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE_BACK,
    ST_MEM_READ,
    ST_UPDATE
  } state_t;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;

endpackage

// File: rtl/dcache_load_align.sv
// Load result formatting: picks byte/half from a word and extends it.
// Misaligned halves drop bit 0; words ignore the byte offset.
module dcache_load_align
  import dcache_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  // select lane, then sign/zero extend by funct3
  always_comb begin
    b = word_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      LD_LB:   data_o = {{24{b[7]}}, b};
      LD_LH:   data_o = {{16{h[15]}}, h};
      LD_LBU:  data_o = {24'd0, b};
      LD_LHU:  data_o = {16'd0, h};
      LD_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped 8x16B write-back, write-allocate data cache.
// Optional hit/miss counters under macro DCACHE_STATS_EN.
module data_cache
  import dcache_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET,
  input  logic [3:0]     READ,
  input  logic [2:0]     WRITE,
  input  logic [31:0]    ADDRESS,
  input  logic [31:0]    WRITEDATA,
  output logic [31:0]    READDATA,
  output logic           BUSYWAIT,
  output logic           MEM_READ,
  output logic           MEM_WRITE,
  output logic [27:0]    MEM_ADDRESS,
  output logic [127:0]   MEM_WRITEDATA,
  input  logic [127:0]   MEM_READDATA,
  input  logic           MEM_BUSYWAIT,
  output logic [31:0]    HIT_COUNT,
  output logic [31:0]    MISS_COUNT
);

  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  state_t            state_q;
  state_t            state_d;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [1:0]        a_word;
  logic [1:0]        a_byte;
  logic              st_req;
  logic              ld_req;
  logic              hit;
  logic              idle;
  logic              acc_hit;
  logic              miss;
  logic [LINE_W-1:0] line;
  logic [31:0]       word;
  logic [31:0]       st_word;
  logic [31:0]       ld_data;

  assign a_tag   = ADDRESS[31:7];
  assign a_idx   = ADDRESS[6:4];
  assign a_word  = ADDRESS[3:2];
  assign a_byte  = ADDRESS[1:0];
  assign st_req  = WRITE[2];
  assign ld_req  = READ[3] & ~WRITE[2];
  assign line    = data_q[a_idx];
  assign word    = line[{a_word, 5'b00000} +: 32];
  assign hit     = valid_q[a_idx] & (tag_q[a_idx] == a_tag);
  assign idle    = (state_q == ST_IDLE);
  assign acc_hit = idle & (st_req | ld_req) & hit;
  assign miss    = idle & (st_req | ld_req) & ~hit;

  dcache_load_align u_align (
    .word_i   (word),
    .off_i    (a_byte),
    .funct3_i (READ[2:0]),
    .data_o   (ld_data)
  );

  assign READDATA = (acc_hit & ld_req) ? ld_data : 32'd0;

  // merge store bytes into the addressed word
  always_comb begin
    st_word = word;
    case (WRITE[1:0])
      STORE_SB: st_word[{a_byte, 3'b000} +: 8] = WRITEDATA[7:0];
      STORE_SH: st_word[{a_byte[1], 4'b0000} +: 16] = WRITEDATA[15:0];
      STORE_SW: st_word = WRITEDATA;
      default:  st_word = WRITEDATA;
    endcase
  end

  // line data and tags: refill on UPDATE, store-hit merge in IDLE
  always_ff @(posedge CLK) begin
    if (RESET && state_q == ST_UPDATE) begin
      data_q[a_idx] <= MEM_READDATA;
      tag_q[a_idx]  <= a_tag;
    end else if (RESET && acc_hit && st_req) begin
      data_q[a_idx][{a_word, 5'b00000} +: 32] <= st_word;
    end
  end

  // valid/dirty bookkeeping
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == ST_UPDATE) begin
      valid_q[a_idx] <= 1'b1;
      dirty_q[a_idx] <= 1'b0;
    end else if (acc_hit && st_req) begin
      dirty_q[a_idx] <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (miss)
          state_d = (valid_q[a_idx] & dirty_q[a_idx])
                    ? ST_WRITE_BACK : ST_MEM_READ;
      ST_WRITE_BACK:
        if (!MEM_BUSYWAIT) state_d = ST_MEM_READ;
      ST_MEM_READ:
        if (!MEM_BUSYWAIT) state_d = ST_UPDATE;
      ST_UPDATE:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: memory strobes and CPU stall
  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = ADDRESS[31:4];
    MEM_WRITEDATA = line;
    BUSYWAIT      = RESET & (miss | ~idle);
    unique case (state_q)
      ST_WRITE_BACK: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {tag_q[a_idx], a_idx};
      end
      ST_MEM_READ: MEM_READ = 1'b1;
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // completed hits and miss-handling entries, wrapping
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (acc_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss)    miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`else
  assign HIT_COUNT  = 32'd0;
  assign MISS_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: hit vectors from a table plus
// hand-written refill, write-back and reset-abort sequences.
module tb_data_cache;

  logic         CLK;
  logic         RESET;
  logic [3:0]   READ;
  logic [2:0]   WRITE;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [3:0] NR  = 4'b0000;
  localparam logic [3:0] LB  = 4'b1000;
  localparam logic [3:0] LH  = 4'b1001;
  localparam logic [3:0] LW  = 4'b1010;
  localparam logic [3:0] LBU = 4'b1100;
  localparam logic [3:0] LHU = 4'b1101;
  localparam logic [2:0] NW  = 3'b000;
  localparam logic [2:0] SB  = 3'b100;
  localparam logic [2:0] SH  = 3'b101;
  localparam logic [2:0] SW  = 3'b110;

  localparam logic [127:0] REFILL1 =
    128'h11112222_33334444_DDDDCCCC_BBBBAAAA;
  localparam logic [127:0] LINE1_DIRTY =
    128'h56782222_A5A5A5A5_DDDDCCCC_BBBB80AA;
  localparam logic [127:0] REFILL9 =
    128'h00000000_CAFE0000_12345678_90ABCDEF;
  localparam logic [127:0] REFILL2 =
    128'h00000000_00000000_00000000_7FFF8000;
  localparam logic [127:0] REFILL4 =
    128'h00000000_00000000_00000000_40404040;

  typedef struct {
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_busy;
  } vec_t;

  vec_t tv[$];
  int   vecs;
  int   miscompares;
  int   exp_hit;
  int   exp_miss;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] rd, input logic [2:0] wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_busy = 1'b0;
    tv.push_back(v);
  endtask

  task automatic drive(input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] a, input logic [31:0] wd);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdata);
      #1;
      chk($sformatf("v%0d rdata", i), READDATA, tv[i].exp_rdata);
      chk($sformatf("v%0d busy", i), BUSYWAIT, tv[i].exp_busy);
      if ((tv[i].rd[3] || tv[i].wr[2]) && !tv[i].exp_busy) exp_hit++;
      step();
    end
    drive(NR, NW, 32'd0, 32'd0);
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, " hits"}, HIT_COUNT, STATS ? exp_hit : 0);
    chk({nm, " misses"}, MISS_COUNT, STATS ? exp_miss : 0);
  endtask

  // read refill: starts in IDLE with the miss request driven
  task automatic refill(input string nm, input logic [27:0] blk,
                        input logic [127:0] d, input logic [31:0] er);
    step();
    chk({nm, " mem_read"}, MEM_READ, 1'b1);
    chk({nm, " mem_write"}, MEM_WRITE, 1'b0);
    chk({nm, " mem_addr"}, MEM_ADDRESS, blk);
    MEM_READDATA = d;
    MEM_BUSYWAIT = 1'b0;
    step();
    MEM_BUSYWAIT = 1'b1;
    chk({nm, " update busy"}, BUSYWAIT, 1'b1);
    chk({nm, " update mem_read"}, MEM_READ, 1'b0);
    step();
    chk({nm, " retry busy"}, BUSYWAIT, 1'b0);
    chk({nm, " retry rdata"}, READDATA, er);
    step();
    exp_hit++;
    drive(NR, NW, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs = 0; miscompares = 0; exp_hit = 0; exp_miss = 0;
    RESET = 1'b0;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    drive(NR, NW, 32'd0, 32'd0);

    add(LW,  NW, 32'h14, 32'h0,        32'hDDDDCCCC);
    add(NR,  SB, 32'h11, 32'h00000080, 32'h0);
    add(LB,  NW, 32'h11, 32'h0,        32'hFFFFFF80);
    add(LBU, NW, 32'h11, 32'h0,        32'h00000080);
    add(LW,  NW, 32'h10, 32'h0,        32'hBBBB80AA);
    add(LB,  NW, 32'h10, 32'h0,        32'hFFFFFFAA);
    add(NR,  SH, 32'h1E, 32'h12345678, 32'h0);
    add(LW,  NW, 32'h1C, 32'h0,        32'h56782222);
    add(LH,  NW, 32'h1F, 32'h0,        32'h00005678);
    add(LB,  NW, 32'h1F, 32'h0,        32'h00000056);
    add(NR,  SW, 32'h18, 32'hA5A5A5A5, 32'h0);
    add(LHU, NW, 32'h1A, 32'h0,        32'h0000A5A5);
    add(LH,  NW, 32'h19, 32'h0,        32'hFFFFA5A5);
    add(NR,  NW, 32'h18, 32'h0,        32'h0);
    add(LW,  NW, 32'h1B, 32'h0,        32'hA5A5A5A5);
    add(LHU, NW, 32'h20, 32'h0,        32'h00008000);
    add(LH,  NW, 32'h20, 32'h0,        32'hFFFF8000);
    add(LHU, NW, 32'h23, 32'h0,        32'h00007FFF);
    add(LB,  NW, 32'h21, 32'h0,        32'hFFFFFF80);
    add(LBU, NW, 32'h22, 32'h0,        32'h000000FF);
    add(LB,  NW, 32'h23, 32'h0,        32'h0000007F);
    add(LW,  SW, 32'h94, 32'hCAFEF00D, 32'h0);
    add(LW,  NW, 32'h94, 32'h0,        32'hCAFEF00D);
    add(LW,  NW, 32'h98, 32'h0,        32'hCAFE0000);
    add(LW,  NW, 32'h90, 32'h0,        32'h90ABCDEF);

    #2;
    chk("rst busy", BUSYWAIT, 1'b0);
    chk("rst mem_read", MEM_READ, 1'b0);
    chk("rst mem_write", MEM_WRITE, 1'b0);
    chk("rst rdata", READDATA, 32'h0);
    drive(LW, NW, 32'h10, 32'h0);
    #1;
    chk("rst req busy", BUSYWAIT, 1'b0);
    chk_counts("rst");
    drive(NR, NW, 32'd0, 32'd0);
    step();
    RESET = 1'b1;

    // cold miss on line 1
    drive(LW, NW, 32'h10, 32'h0);
    #1;
    chk("m1 busy", BUSYWAIT, 1'b1);
    chk("m1 rdata", READDATA, 32'h0);
    exp_miss++;
    refill("m1", 28'h1, REFILL1, 32'hBBBBAAAA);
    chk_counts("m1");

    run_range(0, 15);

    // dirty victim: write-back then refill
    drive(LW, NW, 32'h90, 32'h0);
    #1;
    chk("wb busy", BUSYWAIT, 1'b1);
    exp_miss++;
    step();
    chk("wb mem_write", MEM_WRITE, 1'b1);
    chk("wb mem_read", MEM_READ, 1'b0);
    chk("wb mem_addr", MEM_ADDRESS, 28'h1);
    chk("wb data", MEM_WRITEDATA, LINE1_DIRTY);
    step();
    chk("wb hold", MEM_WRITE, 1'b1);
    MEM_BUSYWAIT = 1'b0;
    step();
    MEM_BUSYWAIT = 1'b1;
    refill("wb", 28'h9, REFILL9, 32'h90ABCDEF);

    drive(LW, NW, 32'h10, 32'h0);
    #1;
    chk("evicted busy", BUSYWAIT, 1'b1);
    drive(NR, NW, 32'd0, 32'd0);
    #1;
    chk("idle busy", BUSYWAIT, 1'b0);
    step();

    // half loads on line 2
    drive(LH, NW, 32'h22, 32'h0);
    #1;
    chk("lh busy", BUSYWAIT, 1'b1);
    exp_miss++;
    refill("lh", 28'h2, REFILL2, 32'h00007FFF);
    run_range(15, 21);

    run_range(21, 25);
    chk_counts("pre-reset");

    // reset aborts a refill in flight
    drive(LW, NW, 32'h40, 32'h0);
    #1;
    chk("ab busy", BUSYWAIT, 1'b1);
    step();
    chk("ab mem_read", MEM_READ, 1'b1);
    #2;
    RESET = 1'b0;
    #1;
    chk("ab rst mem_read", MEM_READ, 1'b0);
    chk("ab rst busy", BUSYWAIT, 1'b0);
    chk("ab rst mem_write", MEM_WRITE, 1'b0);
    exp_hit = 0;
    exp_miss = 0;
    chk_counts("ab rst");
    MEM_BUSYWAIT = 1'b0;
    step();
    RESET = 1'b1;
    MEM_BUSYWAIT = 1'b1;
    #1;
    chk("ab again busy", BUSYWAIT, 1'b1);
    exp_miss++;
    refill("ab", 28'h4, REFILL4, 32'h40404040);

    drive(LW, NW, 32'h94, 32'h0);
    #1;
    chk("post-rst miss", BUSYWAIT, 1'b1);
    drive(NR, NW, 32'd0, 32'd0);
    #1;
    chk_counts("end");

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

endmodule
